// File: rtl/vdma_pkg.sv
// Shared definitions for the VDMA write path: burst-writer FSM encoding and
// the byte size of one pixel word.
package vdma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_REQ,
        ST_DATA,
        ST_DONE
    } wr_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/vdma_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and a
// synchronous flush that discards all stored words.
module vdma_sync_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                     video_source_clk_i,
    input  logic                     video_source_clk_rst_i,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_FULL);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge video_source_clk_i) begin
        if (video_source_clk_rst_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            // Simultaneous write and read leaves the occupancy unchanged.
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge video_source_clk_i) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/vdma_burst_writer.sv
// Buffers a frame of pixel words and writes it to memory as a sequence of
// address/length requests, each followed by its data beats.
module vdma_burst_writer
    import vdma_pkg::*;
#(
    parameter int G_BURST_LEN  = 16,
    parameter int G_FIFO_DEPTH = 64
) (
    input  logic        video_source_clk_i,
    input  logic        video_source_clk_rst_i,
    input  logic        frame_start_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_i,
    input  logic [31:0] ddr_wr_addr_i,
    input  logic [23:0] frame_words_i,
    output logic        wr_req_o,
    output logic [31:0] wr_addr_o,
    output logic [7:0]  wr_len_o,
    input  logic        wr_ack_i,
    output logic [31:0] wr_data_o,
    output logic        wr_data_valid_o,
    input  logic        wr_data_ready_i,
    output logic        mem_wr_done_o,
    output logic        overflow_o
);

    localparam int CW = $clog2(G_FIFO_DEPTH) + 1;

    wr_state_t   state, state_nxt;
    logic        frame_start_d, frame_start;
    logic [31:0] base_addr, pend_addr, load_addr;
    logic [23:0] frame_words, pend_words, load_words;
    logic [23:0] accepted_cnt, issued_cnt, remaining;
    logic [7:0]  burst_len, burst_len_calc, beat_cnt;
    logic        restart_pend, start_now, restart_now, load;
    logic        beat, last_beat, in_frame, ovf_set, overflow;
    logic        fifo_wr, fifo_empty, fifo_full;
    logic [31:0] fifo_dout;
    logic [CW-1:0] fifo_count;

    assign frame_start    = frame_start_i && !frame_start_d;
    assign remaining      = frame_words - issued_cnt;
    assign burst_len_calc = (remaining >= 24'(G_BURST_LEN)) ? 8'(G_BURST_LEN) : remaining[7:0];
    assign beat           = (state == ST_DATA) && !fifo_empty && wr_data_ready_i;
    assign last_beat      = beat && (beat_cnt == burst_len - 8'd1);

    // A frame start while a request is outstanding waits for that burst's last
    // beat; the newest start always supplies the frame parameters.
    assign start_now   = frame_start && (state == ST_IDLE || state == ST_FILL || state == ST_DONE);
    assign restart_now = last_beat && (restart_pend || frame_start);
    assign load        = start_now || restart_now;
    assign load_addr   = frame_start ? ddr_wr_addr_i : pend_addr;
    assign load_words  = frame_start ? frame_words_i : pend_words;

    assign in_frame = accepted_cnt < frame_words;
    assign fifo_wr  = data_valid_i && !fifo_full && in_frame && !load;
    assign ovf_set  = data_valid_i && fifo_full && in_frame && !load;

    vdma_sync_fifo #(
        .DEPTH (G_FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .video_source_clk_i     (video_source_clk_i),
        .video_source_clk_rst_i (video_source_clk_rst_i),
        .flush                  (load),
        .wr_en                  (fifo_wr),
        .wr_data                (data_i),
        .rd_en                  (beat),
        .rd_data                (fifo_dout),
        .empty                  (fifo_empty),
        .full                   (fifo_full),
        .count                  (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_IDLE;
            ST_FILL: if (32'(fifo_count) >= 32'(burst_len_calc)) state_nxt = ST_REQ;
            ST_REQ:  if (wr_ack_i) state_nxt = ST_DATA;
            ST_DATA: if (last_beat) state_nxt = (remaining == 24'd0) ? ST_DONE : ST_FILL;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (load) state_nxt = (load_words == 24'd0) ? ST_DONE : ST_FILL;
    end

    always_ff @(posedge video_source_clk_i) begin
        if (video_source_clk_rst_i) begin
            state         <= ST_IDLE;
            frame_start_d <= 1'b0;
            base_addr     <= '0;
            frame_words   <= '0;
            pend_addr     <= '0;
            pend_words    <= '0;
            restart_pend  <= 1'b0;
            accepted_cnt  <= '0;
            issued_cnt    <= '0;
            burst_len     <= '0;
            beat_cnt      <= '0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_nxt;
            frame_start_d <= frame_start_i;
            if (load) begin
                base_addr    <= load_addr;
                frame_words  <= load_words;
                accepted_cnt <= '0;
                issued_cnt   <= '0;
                overflow     <= 1'b0;
                restart_pend <= 1'b0;
            end else begin
                if (fifo_wr) accepted_cnt <= accepted_cnt + 24'd1;
                if (ovf_set) overflow <= 1'b1;
                if (frame_start && (state == ST_REQ || state == ST_DATA)) begin
                    restart_pend <= 1'b1;
                    pend_addr    <= ddr_wr_addr_i;
                    pend_words   <= frame_words_i;
                end
                if (state == ST_FILL && state_nxt == ST_REQ) burst_len <= burst_len_calc;
                if (state == ST_REQ && wr_ack_i) begin
                    issued_cnt <= issued_cnt + 24'(burst_len);
                    beat_cnt   <= '0;
                end
                if (beat) beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

    // Request address counts words already handed to earlier bursts.
    assign wr_req_o        = (state == ST_REQ);
    assign wr_addr_o       = wr_req_o ? base_addr + 32'(issued_cnt) * 32'(BYTES_PER_WORD) : 32'd0;
    assign wr_len_o        = wr_req_o ? burst_len - 8'd1 : 8'd0;
    assign wr_data_valid_o = (state == ST_DATA) && !fifo_empty;
    assign wr_data_o       = wr_data_valid_o ? fifo_dout : 32'd0;
    assign mem_wr_done_o   = (state == ST_DONE);
    assign overflow_o      = overflow;

endmodule

// File: tb/tb_vdma_burst_writer.sv
// Bench for vdma_burst_writer: a table of whole-frame vectors plus directed
// sequences for overflow, mid-burst restart and mid-burst reset.
module tb_vdma_burst_writer;

    localparam int BL = 16;
    localparam int FD = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start_i = 1'b0;
    logic        data_valid_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [31:0] ddr_wr_addr_i = '0;
    logic [23:0] frame_words_i = '0;
    logic        wr_req_o;
    logic [31:0] wr_addr_o;
    logic [7:0]  wr_len_o;
    logic        wr_ack_i = 1'b0;
    logic [31:0] wr_data_o;
    logic        wr_data_valid_o;
    logic        wr_data_ready_i = 1'b0;
    logic        mem_wr_done_o;
    logic        overflow_o;

    vdma_burst_writer #(.G_BURST_LEN(BL), .G_FIFO_DEPTH(FD)) dut (
        .video_source_clk_i     (clk),
        .video_source_clk_rst_i (rst),
        .frame_start_i          (frame_start_i),
        .data_valid_i           (data_valid_i),
        .data_i                 (data_i),
        .ddr_wr_addr_i          (ddr_wr_addr_i),
        .frame_words_i          (frame_words_i),
        .wr_req_o               (wr_req_o),
        .wr_addr_o              (wr_addr_o),
        .wr_len_o               (wr_len_o),
        .wr_ack_i               (wr_ack_i),
        .wr_data_o              (wr_data_o),
        .wr_data_valid_o        (wr_data_valid_o),
        .wr_data_ready_i        (wr_data_ready_i),
        .mem_wr_done_o          (mem_wr_done_o),
        .overflow_o             (overflow_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] req_addr_q[$];
    logic [7:0]  req_len_q[$];
    int          beat_cnt = 0;
    int          done_cnt = 0;
    logic        chk_en = 1'b1;
    logic        ack_en = 1'b1;
    int          ready_mode = 0;
    int          req_age = 0;
    logic        stalled = 1'b0;
    logic [31:0] stall_data = '0;
    logic        req_hold = 1'b0;
    logic [31:0] hold_addr = '0;
    logic [7:0]  hold_len = '0;

    typedef struct {
        logic [31:0]      base;
        logic [23:0]      words;
        int               ready_mode;
        int               n_bursts;
        logic [2:0][31:0] addr;
        logic [2:0][7:0]  len;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ready pattern: 0 = always ready, 1 = toggling every cycle, else never ready.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       wr_data_ready_i = 1'b1;
            1:       wr_data_ready_i = ~wr_data_ready_i;
            default: wr_data_ready_i = 1'b0;
        endcase
    end

    // Memory side accepts each request two cycles after it appears.
    always @(posedge clk) begin
        #1;
        if (wr_ack_i) begin
            wr_ack_i = 1'b0;
            req_age  = 0;
        end else if (wr_req_o && ack_en) begin
            req_age++;
            if (req_age >= 2) wr_ack_i = 1'b1;
        end else begin
            req_age = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (stalled) begin
                check("stall_valid", 32'(wr_data_valid_o), 32'd1);
                check("stall_data", wr_data_o, stall_data);
            end
            if (wr_data_valid_o && wr_data_ready_i) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_extra: got 0x%08h expected no beat", wr_data_o);
                end else begin
                    check("beat_data", wr_data_o, exp_q.pop_front());
                end
            end
            if (wr_req_o) begin
                if (req_hold) begin
                    check("req_addr_stable", wr_addr_o, hold_addr);
                    check("req_len_stable", 32'(wr_len_o), 32'(hold_len));
                end
                if (wr_ack_i) begin
                    req_addr_q.push_back(wr_addr_o);
                    req_len_q.push_back(wr_len_o);
                end
            end
            if (mem_wr_done_o) done_cnt++;
        end
        stalled    = chk_en && !rst && wr_data_valid_o && !wr_data_ready_i;
        stall_data = wr_data_o;
        req_hold   = chk_en && !rst && wr_req_o && !wr_ack_i;
        hold_addr  = wr_addr_o;
        hold_len   = wr_len_o;
    end

    function automatic vec_t mk_vec(input logic [31:0] base, input logic [23:0] words,
                                    input int mode, input int nb,
                                    input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                                    input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2);
        vec_t v;
        v.base = base; v.words = words; v.ready_mode = mode; v.n_bursts = nb;
        v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
        v.len[0] = l0;  v.len[1] = l1;  v.len[2] = l2;
        return v;
    endfunction

    task automatic clear_sb();
        exp_q.delete();
        req_addr_q.delete();
        req_len_q.delete();
        beat_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic start_frame(input logic [31:0] base, input logic [23:0] words);
        ddr_wr_addr_i = base;
        frame_words_i = words;
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        tick();
    endtask

    task automatic feed(input int n, input logic [31:0] seed, input int push_n);
        for (int i = 0; i < n; i++) begin
            data_valid_i = 1'b1;
            data_i = seed + 32'(i);
            if (i < push_n) exp_q.push_back(data_i);
            tick();
        end
        data_valid_i = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string name);
        int c = 0;
        while (beat_cnt < n && c < 2000) begin
            tick();
            c++;
        end
        check(name, 32'(beat_cnt >= n), 32'd1);
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (done_cnt == 0 && c < 2000) begin
            tick();
            c++;
        end
        check(name, 32'(done_cnt > 0), 32'd1);
        tick(3);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_req"}, 32'(wr_req_o), 32'd0);
        check({tag, "_wr_addr"}, wr_addr_o, 32'd0);
        check({tag, "_wr_len"}, 32'(wr_len_o), 32'd0);
        check({tag, "_wr_data"}, wr_data_o, 32'd0);
        check({tag, "_wr_valid"}, 32'(wr_data_valid_o), 32'd0);
        check({tag, "_done"}, 32'(mem_wr_done_o), 32'd0);
        check({tag, "_overflow"}, 32'(overflow_o), 32'd0);
    endtask

    task automatic check_reqs(input string tag, input int nb, input logic [2:0][31:0] addr,
                              input logic [2:0][7:0] len);
        check({tag, "_n_bursts"}, 32'(req_addr_q.size()), 32'(nb));
        for (int i = 0; i < nb && i < req_addr_q.size(); i++) begin
            check({tag, "_burst_addr"}, req_addr_q[i], addr[i]);
            check({tag, "_burst_len"}, 32'(req_len_q[i]), 32'(len[i]));
        end
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        clear_sb();
        ready_mode = v.ready_mode;
        ack_en = 1'b1;
        start_frame(v.base, v.words);
        feed(int'(v.words), 32'hA500_0000 + (32'(idx) << 16), int'(v.words));
        wait_done("vec_done_seen");
        check_reqs("vec", v.n_bursts, v.addr, v.len);
        check("vec_n_beats", 32'(beat_cnt), 32'(v.words));
        check("vec_exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("vec_done_pulses", 32'(done_cnt), 32'd1);
        check("vec_overflow", 32'(overflow_o), 32'd0);
        ready_mode = 0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0][31:0] a;
        logic [2:0][7:0]  l;

        vecs.push_back(mk_vec(32'h1000_0000, 24'd40, 0, 3, 32'h1000_0000, 32'h1000_0040, 32'h1000_0080, 8'd15, 8'd15, 8'd7));
        vecs.push_back(mk_vec(32'h2000_0100, 24'd16, 1, 1, 32'h2000_0100, 32'h0, 32'h0, 8'd15, 8'd0, 8'd0));
        vecs.push_back(mk_vec(32'hFFFF_FFE0, 24'd32, 0, 2, 32'hFFFF_FFE0, 32'h0000_0020, 32'h0, 8'd15, 8'd15, 8'd0));
        vecs.push_back(mk_vec(32'h0000_0400, 24'd5, 1, 1, 32'h0000_0400, 32'h0, 32'h0, 8'd4, 8'd0, 8'd0));
        vecs.push_back(mk_vec(32'h0000_0800, 24'd0, 0, 0, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, 8'd0));

        rst = 1'b1;
        tick(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < vecs.size(); i++) run_vector(vecs[i], i);

        // Overflow: no ack, FIFO fills, extra words are dropped.
        clear_sb();
        ack_en = 1'b0;
        start_frame(32'h5000_0000, 24'd100);
        feed(FD, 32'hB000_0000, BL);
        tick(2);
        check("ovf_before_full", 32'(overflow_o), 32'd0);
        feed(5, 32'hB000_0040, 0);
        check("ovf_set", 32'(overflow_o), 32'd1);
        check("ovf_req_waiting", 32'(wr_req_o), 32'd1);
        ddr_wr_addr_i = 32'h6000_0000;
        frame_words_i = 24'd8;
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        ack_en = 1'b1;
        wait_beats(BL, "ovf_drain_beats");
        tick(3);
        check("ovf_cleared", 32'(overflow_o), 32'd0);
        check("ovf_no_done_aborted", 32'(done_cnt), 32'd0);
        feed(8, 32'hC000_0000, 8);
        wait_done("ovf_new_frame_done");
        a = '0; l = '0;
        a[0] = 32'h5000_0000; l[0] = 8'd15;
        a[1] = 32'h6000_0000; l[1] = 8'd7;
        check_reqs("ovf", 2, a, l);
        check("ovf_done_pulses", 32'(done_cnt), 32'd1);

        // Frame start during the data phase of a burst, at beat 5.
        clear_sb();
        start_frame(32'h2000_0000, 24'd32);
        feed(20, 32'hD000_0000, BL);
        wait_beats(5, "abort_reach_beat5");
        ddr_wr_addr_i = 32'h3000_0000;
        frame_words_i = 24'd16;
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        wait_beats(BL, "abort_burst_complete");
        tick(3);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_beats_in_burst", 32'(beat_cnt), 32'(BL));
        feed(16, 32'hE000_0000, 16);
        wait_done("abort_new_frame_done");
        a = '0; l = '0;
        a[0] = 32'h2000_0000; l[0] = 8'd15;
        a[1] = 32'h3000_0000; l[1] = 8'd15;
        check_reqs("abort", 2, a, l);
        check("abort_done_pulses", 32'(done_cnt), 32'd1);
        check("abort_total_beats", 32'(beat_cnt), 32'd32);

        // Reset at beat 3 of a burst, then a normal frame.
        clear_sb();
        start_frame(32'h4000_0000, 24'd16);
        feed(16, 32'hF000_0000, 16);
        wait_beats(3, "rst_reach_beat3");
        chk_en = 1'b0;
        rst = 1'b1;
        tick();
        check_outputs_zero("rst_mid");
        rst = 1'b0;
        tick(4);
        check_outputs_zero("rst_after");
        exp_q.delete();
        chk_en = 1'b1;
        run_vector(vecs[0], 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vdma_burst_writer.md
VDMA_BURST_WRITER -- requirements
Module: vdma_burst_writer

Interface
REQ-001 SHALL have parameter G_BURST_LEN, default 16, meaning beats per full write burst (power of 2, 2..64).
REQ-002 SHALL have parameter G_FIFO_DEPTH, default 64, meaning pixel-word buffer depth (power of 2, at least 2*G_BURST_LEN).
REQ-003 SHALL have one clock and synchronous active-high reset: video_source_clk_i in 1 (sole clock), video_source_clk_rst_i in 1 (synchronous, active-high).
REQ-004 SHALL have ports, each `name  direction  width  meaning`:
  frame_start_i  in 1  gated frame start from the DMA controller, level.
  data_valid_i  in 1  gated pixel-word strobe.
  data_i  in 32  pixel word.
  ddr_wr_addr_i  in 32  frame base byte address, sampled at frame start.
  frame_words_i  in 24  words per frame, sampled at frame start.
  wr_req_o  out 1  burst request.
  wr_addr_o  out 32  burst byte address.
  wr_len_o  out 8  beats minus one.
  wr_ack_i  in 1  burst request accepted.
  wr_data_o  out 32  burst beat data.
  wr_data_valid_o  out 1  beat valid.
  wr_data_ready_i  in 1  beat accepted.
  mem_wr_done_o  out 1  one-cycle pulse when a frame is fully written.
  overflow_o  out 1  sticky: a word was dropped in the current frame.

Function
REQ-005 Frame start SHALL be the rising edge of frame_start_i, detected against a one-cycle delayed copy.
REQ-006 At frame start SHALL latch ddr_wr_addr_i and frame_words_i, clear the word counters, clear overflow_o, and flush the FIFO.
REQ-007 A word SHALL be written to the FIFO when data_valid_i=1, the FIFO is not full, and accepted-word count < latched frame_words; words beyond frame_words SHALL be dropped silently.
REQ-008 data_valid_i with FIFO full SHALL drop the word and set overflow_o=1 until the next frame start.
REQ-009 FSM states: IDLE, FILL, REQ, DATA, DONE.
REQ-010 IDLE -> FILL on frame start; a frame_words_i value of 0 SHALL go IDLE -> DONE directly.
REQ-011 In FILL, burst length L = min(G_BURST_LEN, remaining words); FILL -> REQ when FIFO count >= L.
REQ-012 In REQ, wr_req_o=1, wr_addr_o = base + 4*words_issued, and wr_len_o = L-1 SHALL be held stable until wr_ack_i=1; then -> DATA.
REQ-013 In DATA, wr_data_valid_o SHALL equal FIFO not-empty with first-word-fall-through; a beat transfers when valid and ready are both 1.
REQ-014 After L beats transfer, DATA SHALL go -> DONE if remaining words = 0, else -> FILL.
REQ-015 DONE SHALL pulse mem_wr_done_o for exactly one cycle, then go -> IDLE.
REQ-016 Address arithmetic SHALL be 32-bit modulo 2^32 and wrap silently; wr_len_o SHALL never exceed G_BURST_LEN-1.
REQ-017 Frame start in FILL SHALL restart the frame immediately with no mem_wr_done_o.
REQ-018 Frame start in REQ or DATA SHALL be remembered; the accepted burst completes, then the frame restarts per REQ-006 with no mem_wr_done_o for the aborted frame.
REQ-019 A simultaneous FIFO write and read SHALL leave the count unchanged.
REQ-020 The FIFO SHALL accept writes in every state, including DATA.

Reset
REQ-021 Reset SHALL force state IDLE, empty the FIFO, zero all counters and latched values, and drive wr_req_o, wr_data_valid_o, mem_wr_done_o, overflow_o = 0 and wr_addr_o, wr_len_o, wr_data_o = 0.
REQ-022 Reset asserted mid-burst SHALL abandon the burst with no further beats after reset.

Structure
REQ-023 The FSM state encoding and the byte-per-word constant (4) SHALL live in shared package vdma_pkg.
REQ-024 The buffer SHALL be sub-module vdma_sync_fifo (FWFT, count output, flush input, parameterised depth and width).

Verification
REQ-025 Base 0x1000_0000, 40 words, ready=1, ack after 2 cycles -> bursts at 0x1000_0000/len 15, 0x1000_0040/len 15, 0x1000_0080/len 7; then one mem_wr_done_o pulse.
REQ-026 frame_words=16 with wr_data_ready_i toggling every cycle -> 16 beats in order with data stable while stalled; one done pulse.
REQ-027 FIFO full (no ack), 5 extra valid words -> overflow_o=1 and words dropped; overflow_o cleared at the next frame start.
REQ-028 Frame start mid-DATA at beat 5 -> burst completes 16 beats, no done pulse, next request at the new base address.
REQ-029 Base 0xFFFF_FFE0, 32 words -> second burst address 0x0000_0020.
REQ-030 Reset at DATA beat 3 -> all outputs 0 on the next cycle, IDLE; a subsequent frame runs normally.
